store_buffer: RTL

- Write-posting buffer between the EX/MEM pipeline register and the data memory in the MEM stage.
- Accepts stores from the M stage, queues them, and drains them to the data memory single port whenever the port is free.
- Loads take priority on the port. Loads that hit a queued store are served from the buffer.
- The port is shared with the NoC interface; `Dmem_Busy` marks cycles when the NoC interface owns it.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/sb_match.sv | 42 ++++
 rtl/store_buffer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared constants and types for the MEM-stage store buffer.
//   ADDR_W    : memory index width compared and stored by the buffer
//   DATA_W    : data word width
//   SB_DEPTH  : default number of buffered stores
//   sb_entry_t: one buffered store {addr, data}
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// ---------------------------------------------------------------------------
// sb_match
// Combinational youngest-match search over the store buffer entries.
//   entry_addr/entry_data : raw entry storage, indexed by slot
//   entry_valid           : per-slot valid mask
//   tail                  : next write slot (youngest entry is tail-1)
//   lookup_addr           : address being searched
//   hit / hit_data        : any valid match, and the data of the youngest one
// ---------------------------------------------------------------------------
module sb_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
  input  logic [DEPTH-1:0]             entry_valid,
  input  logic [PTR_W-1:0]             tail,
  input  logic [ADDR_W-1:0]            lookup_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            hit_data
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last match
  // written wins, so the youngest store supplies the data.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = tail - PTR_W'(k + 1);
      if (entry_valid[idx] && (entry_addr[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Write-posting buffer between the EX/MEM register and the single-port data
// memory. Stores are queued and drained whenever the port is free; loads have
// priority on the port; loads hitting a queued store are forwarded.
// Optional feature macro: STORE_BUF_FWD_EN (store-to-load forwarding). When
// undefined, a hitting load stalls until the matching stores have drained.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   Mem_Write_M/Read_M   : M-stage store / load request
//   ALU_result_M         : address (low ADDR_W bits used)
//   Write_Data_M         : store data
//   Stall_M              : request not accepted this cycle
//   Drain_Req            : empty the buffer, blocking new requests
//   Dmem_Busy            : NoC interface owns the memory port
//   Buf_Empty            : no pending stores
//   Dmem_Write/Read/Addr/Wdata/Rdata : data memory port
//   Load_Data            : load result, one cycle after accepted load
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH  = mem_pkg::SB_DEPTH,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Mem_Write_M,
  input  logic              Mem_Read_M,
  input  logic [31:0]       ALU_result_M,
  input  logic [DATA_W-1:0] Write_Data_M,
  output logic              Stall_M,
  input  logic              Drain_Req,
  input  logic              Dmem_Busy,
  output logic              Buf_Empty,
  output logic              Dmem_Write,
  output logic              Dmem_Read,
  output logic [31:0]       Dmem_Addr,
  output logic [DATA_W-1:0] Dmem_Wdata,
  input  logic [DATA_W-1:0] Dmem_Rdata,
  output logic [DATA_W-1:0] Load_Data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] entry_data_q;
  logic [DEPTH-1:0]             entry_valid;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_q, rd_d;

  logic [ADDR_W-1:0] lookup_addr;
  logic              match_hit;
  logic [DATA_W-1:0] match_data;
  logic              is_store, is_load;
  logic              load_fwd, load_miss_go;
  logic              push, pop;

  logic unused_addr_hi;
  assign unused_addr_hi = ^ALU_result_M[31:ADDR_W];

  assign lookup_addr = ALU_result_M[ADDR_W-1:0];

  // A slot is valid when its distance from head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PTR_W-1:0] offset;
    assign offset          = PTR_W'(gi) - head_q;
    assign entry_valid[gi] = {1'b0, offset} < count_q;
  end

  sb_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .PTR_W (PTR_W)
  ) u_match (
    .entry_addr (entry_addr_q),
    .entry_data (entry_data_q),
    .entry_valid(entry_valid),
    .tail       (tail_q),
    .lookup_addr(lookup_addr),
    .hit        (match_hit),
    .hit_data   (match_data)
  );

`ifdef STORE_BUF_FWD_EN
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] fwd_q, fwd_d;
`else
  logic unused_fwd;
  assign unused_fwd = ^match_data;
`endif

  always_comb begin
    // Simultaneous read+write is a store only.
    is_store     = Mem_Write_M;
    is_load      = Mem_Read_M & ~Mem_Write_M;
    load_miss_go = is_load & ~match_hit & ~Drain_Req & ~Dmem_Busy;
`ifdef STORE_BUF_FWD_EN
    load_fwd     = is_load & match_hit & ~Drain_Req;
`else
    load_fwd     = 1'b0;
`endif
    // Loads own the port first; a pop only uses an otherwise idle port.
    pop          = ~Dmem_Busy & ~load_miss_go & (count_q != '0);
    push         = is_store & ~Drain_Req & ((count_q != CNT_W'(DEPTH)) | pop);

    Stall_M      = (is_store & ~push) | (is_load & ~(load_fwd | load_miss_go));
    Dmem_Read    = load_miss_go;
    Dmem_Write   = pop;
    Dmem_Addr    = '0;
    Dmem_Wdata   = '0;
    if (load_miss_go) begin
      Dmem_Addr = 32'(lookup_addr);
    end else if (pop) begin
      Dmem_Addr  = 32'(entry_addr_q[head_q]);
      Dmem_Wdata = entry_data_q[head_q];
    end
    Buf_Empty    = (count_q == '0);

    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_d    = load_miss_go;
`ifdef STORE_BUF_FWD_EN
    hit_d     = load_fwd;
    fwd_d     = load_fwd ? match_data : '0;
    Load_Data = hit_q ? fwd_q : (rd_q ? Dmem_Rdata : '0);
`else
    Load_Data = rd_q ? Dmem_Rdata : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rd_q    <= 1'b0;
`ifdef STORE_BUF_FWD_EN
      hit_q   <= 1'b0;
      fwd_q   <= '0;
`endif
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rd_q    <= rd_d;
`ifdef STORE_BUF_FWD_EN
      hit_q   <= hit_d;
      fwd_q   <= fwd_d;
`endif
    end
  end

  // Entry payload needs no reset: validity comes from head/count only.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr_q[tail_q] <= lookup_addr;
      entry_data_q[tail_q] <= Write_Data_M;
    end
  end

endmodule
